// File: rtl/memgame_pkg.sv
// Shared definitions for the memory-game core: FSM state encodings and the
// 16-bit Fibonacci LFSR (taps 16,14,13,11) with its default seed.
package memgame_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        GEN   = 3'd1,
        SHOW  = 3'd2,
        INPUT = 3'd3,
        WIN   = 3'd4,
        LOSE  = 3'd5
    } game_state_e;

    localparam logic [15:0] LFSR_TAPS         = 16'hB400;
    localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {cur[14:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/memgame_tick_keys.sv
// Game-tick divider plus tick-rate key synchroniser and press detector.
// Keys are active-low; each press yields exactly one event, aligned with a tick.
module memgame_tick_keys #(
    parameter int TICK_DIV = 3500000
) (
    input  logic clk,
    input  logic reset,
    input  logic start_n,
    input  logic enter_n,
    output logic tick,
    output logic start_evt,
    output logic enter_evt
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] div_q;
    logic [1:0]    start_sync_q;
    logic [1:0]    enter_sync_q;

    assign tick = (div_q == CW'(TICK_DIV - 1));

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of process ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q        <= '0;
            start_sync_q <= 2'b11;
            enter_sync_q <= 2'b11;
        end else begin
            div_q <= tick ? '0 : div_q + 1'b1;
            if (tick) begin
                start_sync_q <= {start_sync_q[0], start_n};
                enter_sync_q <= {enter_sync_q[0], enter_n};
            end
        end
    end

    // Bit 1 is the older sample: a 1 followed by a 0 is one press.
    assign start_evt = tick & start_sync_q[1] & ~start_sync_q[0];
    assign enter_evt = tick & enter_sync_q[1] & ~enter_sync_q[0];

endmodule

// File: rtl/memory_game_seq.sv
// Memory-game core: LFSR digit generator, sequence store, show/input FSM.
// Optional entry timeout is built only when MEMGAME_TIMEOUT_EN is defined.
module memory_game_seq
    import memgame_pkg::*;
#(
    parameter int          SEQ_LEN       = 4,
    parameter int          DIGIT_W       = 4,
    parameter int          DIGIT_MAX     = 9,
    parameter int          TICK_DIV      = 3500000,
    parameter int          SHOW_TICKS    = 8,
    parameter logic [15:0] LFSR_SEED     = LFSR_SEED_DEFAULT,
    parameter int          TIMEOUT_TICKS = 40
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start_n,
    input  logic                         enter_n,
    input  logic [DIGIT_W-1:0]           num,
    output logic [DIGIT_W-1:0]           show_digit,
    output logic                         show_valid,
    output logic [SEQ_LEN-1:0]           match_flags,
    output logic [$clog2(SEQ_LEN+1)-1:0] progress,
    output logic [2:0]                   state_o,
    output logic                         win,
    output logic                         lose
);

    localparam int IW = $clog2(SEQ_LEN);
    localparam int PW = $clog2(SEQ_LEN + 1);
    localparam int SW = $clog2(SHOW_TICKS + 1);

    if (SEQ_LEN < 2 || SEQ_LEN > 16) begin : g_bad_seq_len
        $error("memory_game_seq: SEQ_LEN must be within 2..16");
    end
    if (DIGIT_MAX >= (1 << DIGIT_W)) begin : g_bad_digit_max
        $error("memory_game_seq: DIGIT_MAX must fit in DIGIT_W bits");
    end
    if (LFSR_SEED == 16'h0000) begin : g_bad_seed
        $error("memory_game_seq: LFSR_SEED must be nonzero");
    end
    if (TIMEOUT_TICKS < 1) begin : g_bad_timeout
        $error("memory_game_seq: TIMEOUT_TICKS must be positive");
    end

    logic tick, start_evt, enter_evt;

    memgame_tick_keys #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_keys (
        .clk       (clk),
        .reset     (reset),
        .start_n   (start_n),
        .enter_n   (enter_n),
        .tick      (tick),
        .start_evt (start_evt),
        .enter_evt (enter_evt)
    );

    game_state_e          state_q, state_d;
    logic [15:0]          lfsr_q;
    logic [DIGIT_W-1:0]   seq_q [SEQ_LEN];
    logic [IW-1:0]        idx_q;
    logic [SW-1:0]        sub_q;
    logic [SEQ_LEN-1:0]   flags_q;
    logic [PW-1:0]        progress_q;

    logic [DIGIT_W-1:0]   raw_digit, new_digit;
    logic                 last_idx, show_done, entry_ok, timeout, enter_gen;

    assign raw_digit = lfsr_q[DIGIT_W-1:0];
    assign new_digit = (raw_digit > DIGIT_W'(DIGIT_MAX))
                     ? raw_digit - DIGIT_W'(DIGIT_MAX + 1) : raw_digit;

    assign last_idx  = (idx_q == IW'(SEQ_LEN - 1));
    assign show_done = tick && (sub_q == SW'(SHOW_TICKS));
    assign entry_ok  = (num == seq_q[idx_q]);
    assign enter_gen = (state_d == GEN) && (state_q != GEN);

`ifdef MEMGAME_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_TICKS + 1);
    logic [TW-1:0] to_cnt_q;

    always_ff @(posedge clk) begin
        if (reset || state_q != INPUT || enter_evt) begin
            to_cnt_q <= '0;
        end else if (tick && !timeout) begin
            to_cnt_q <= to_cnt_q + 1'b1;
        end
    end

    assign timeout = (to_cnt_q == TW'(TIMEOUT_TICKS));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // NOTE: state_d takes a default before the case so no path infers a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start_evt) state_d = GEN;
            GEN:  if (last_idx)  state_d = SHOW;
            SHOW: begin
                if (start_evt)                  state_d = GEN;
                else if (show_done && last_idx) state_d = INPUT;
            end
            INPUT: begin
                // Start outranks enter on the same tick.
                if (start_evt) begin
                    state_d = GEN;
                end else if (enter_evt) begin
                    if (!entry_ok)     state_d = LOSE;
                    else if (last_idx) state_d = WIN;
                end else if (timeout) begin
                    state_d = LOSE;
                end
            end
            WIN, LOSE: if (start_evt) state_d = GEN;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q     <= LFSR_SEED;
            idx_q      <= '0;
            sub_q      <= '0;
            flags_q    <= '0;
            progress_q <= '0;
        end else begin
            lfsr_q <= lfsr_next(lfsr_q);
            if (enter_gen) begin
                idx_q      <= '0;
                flags_q    <= '0;
                progress_q <= '0;
            end else begin
                unique case (state_q)
                    GEN: begin
                        idx_q <= last_idx ? '0 : idx_q + 1'b1;
                        sub_q <= '0;
                    end
                    SHOW: if (tick) begin
                        // SHOW_TICKS display ticks, then one blank gap tick.
                        if (sub_q == SW'(SHOW_TICKS)) begin
                            sub_q <= '0;
                            idx_q <= last_idx ? '0 : idx_q + 1'b1;
                        end else begin
                            sub_q <= sub_q + 1'b1;
                        end
                    end
                    INPUT: if (enter_evt && entry_ok) begin
                        flags_q[idx_q] <= 1'b1;
                        progress_q     <= progress_q + 1'b1;
                        if (!last_idx) idx_q <= idx_q + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // NOTE: the sequence store has no reset; GEN writes every entry before use.
    always_ff @(posedge clk) begin
        if (state_q == GEN) seq_q[idx_q] <= new_digit;
    end

    assign show_valid  = (state_q == SHOW) && (sub_q < SW'(SHOW_TICKS));
    assign show_digit  = show_valid ? seq_q[idx_q] : '0;
    assign match_flags = flags_q;
    assign progress    = progress_q;
    assign state_o     = state_q;
    assign win         = (state_q == WIN);
    assign lose        = (state_q == LOSE);

endmodule
